// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the load formatter, ALU control and main control.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_lane_select.sv
// Picks the addressed byte and halfword out of a little-endian memory word.
module load_lane_select (
  input  logic [31:0] RawMem,
  input  logic [1:0]  ByteOff,
  output logic [7:0]  lane_byte,
  output logic [15:0] lane_half
);

  always_comb begin
    lane_byte = RawMem[7:0];
    case (ByteOff)
      2'd0: lane_byte = RawMem[7:0];
      2'd1: lane_byte = RawMem[15:8];
      2'd2: lane_byte = RawMem[23:16];
      2'd3: lane_byte = RawMem[31:24];
      default: lane_byte = RawMem[7:0];
    endcase
  end

  // Halfword lane uses only the upper offset bit; an odd offset is flagged upstream.
  assign lane_half = ByteOff[1] ? RawMem[31:16] : RawMem[15:0];

endmodule

// File: rtl/mem_sign_extender.sv
// Load-data formatter: lane select, zero/sign extension and alignment/encoding flags.
module mem_sign_extender
  import riscv_pkg::*;
#(
  parameter int XLEN    = riscv_pkg::XLEN,
  parameter bit REG_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] RawMem,
  input  logic [1:0]      ByteOff,
  input  logic [2:0]      funct3,
  input  logic            MemRdSignExtend,
  output logic [XLEN-1:0] ExtendedMem,
  output logic            Misaligned,
  output logic            IllegalF3
);

  logic [7:0]      lane_byte;
  logic [15:0]     lane_half;
  logic [XLEN-1:0] ext_d;
  logic            mis_d;
  logic            ill_d;

  load_lane_select u_lane_select (
    .RawMem    (RawMem),
    .ByteOff   (ByteOff),
    .lane_byte (lane_byte),
    .lane_half (lane_half)
  );

  always_comb begin
    ext_d = RawMem;
    mis_d = 1'b0;
    ill_d = 1'b0;
    if (MemRdSignExtend) begin
      case (funct3)
        F3_LB:  ext_d = {{24{lane_byte[7]}}, lane_byte};
        F3_LBU: ext_d = {24'b0, lane_byte};
        F3_LH: begin
          ext_d = {{16{lane_half[15]}}, lane_half};
          mis_d = ByteOff[0];
        end
        F3_LHU: begin
          ext_d = {16'b0, lane_half};
          mis_d = ByteOff[0];
        end
        F3_LW:  mis_d = |ByteOff;
        3'b011, 3'b110, 3'b111: ill_d = 1'b1;
        default: ill_d = 1'b1;
      endcase
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      always_ff @(posedge clk) begin
        if (reset) begin
          ExtendedMem <= '0;
          Misaligned  <= 1'b0;
          IllegalF3   <= 1'b0;
        end else begin
          ExtendedMem <= ext_d;
          Misaligned  <= mis_d;
          IllegalF3   <= ill_d;
        end
      end
    end else begin : g_comb
      assign ExtendedMem = ext_d;
      assign Misaligned  = mis_d;
      assign IllegalF3   = ill_d;
    end
  endgenerate

endmodule

// File: tb/tb_mem_sign_extender.sv
// Directed vector bench for mem_sign_extender with registered outputs.
module tb_mem_sign_extender;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] RawMem;
  logic [1:0]  ByteOff;
  logic [2:0]  funct3;
  logic        MemRdSignExtend;
  logic [31:0] ExtendedMem;
  logic        Misaligned;
  logic        IllegalF3;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] raw;
    logic [1:0]  off;
    logic [2:0]  f3;
    logic        en;
    logic [31:0] exp_data;
    logic        exp_mis;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];

  mem_sign_extender #(.XLEN(32), .REG_OUT(1'b1)) dut (
    .clk             (clk),
    .reset           (reset),
    .RawMem          (RawMem),
    .ByteOff         (ByteOff),
    .funct3          (funct3),
    .MemRdSignExtend (MemRdSignExtend),
    .ExtendedMem     (ExtendedMem),
    .Misaligned      (Misaligned),
    .IllegalF3       (IllegalF3)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [31:0] raw, input logic [1:0] off, input logic [2:0] f3,
                     input logic en, input logic [31:0] d, input logic m, input logic i);
    vec_t v;
    v.raw = raw; v.off = off; v.f3 = f3; v.en = en;
    v.exp_data = d; v.exp_mis = m; v.exp_ill = i;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    RawMem = v.raw; ByteOff = v.off; funct3 = v.f3; MemRdSignExtend = v.en;
  endtask

  task automatic check(input string name, input logic [31:0] d, input logic m, input logic i);
    n_vec++;
    if (ExtendedMem !== d || Misaligned !== m || IllegalF3 !== i) begin
      n_err++;
      $display("FAIL %s: got data=%08h mis=%0b ill=%0b, want data=%08h mis=%0b ill=%0b",
               name, ExtendedMem, Misaligned, IllegalF3, d, m, i);
    end
  endtask

  initial begin
    // Bytes
    add(32'h80FF7F01, 2'd0, 3'b000, 1'b1, 32'h00000001, 1'b0, 1'b0);
    add(32'h80FF7F01, 2'd1, 3'b000, 1'b1, 32'h0000007F, 1'b0, 1'b0);
    add(32'h80FF7F01, 2'd2, 3'b000, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    add(32'h80FF7F01, 2'd3, 3'b000, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0);
    add(32'h80FF7F01, 2'd3, 3'b100, 1'b1, 32'h00000080, 1'b0, 1'b0);
    add(32'h80FF7F01, 2'd2, 3'b100, 1'b1, 32'h000000FF, 1'b0, 1'b0);
    // Halfwords
    add(32'h80017FFE, 2'd0, 3'b001, 1'b1, 32'h00007FFE, 1'b0, 1'b0);
    add(32'h80017FFE, 2'd2, 3'b001, 1'b1, 32'hFFFF8001, 1'b0, 1'b0);
    add(32'h80017FFE, 2'd2, 3'b101, 1'b1, 32'h00008001, 1'b0, 1'b0);
    add(32'h80017FFE, 2'd1, 3'b001, 1'b1, 32'h00007FFE, 1'b1, 1'b0);
    add(32'h80017FFE, 2'd3, 3'b101, 1'b1, 32'h00008001, 1'b1, 1'b0);
    add(32'h80017FFE, 2'd0, 3'b101, 1'b1, 32'h00007FFE, 1'b0, 1'b0);
    // Words and bypass
    add(32'hDEADBEEF, 2'd0, 3'b010, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    add(32'hDEADBEEF, 2'd2, 3'b010, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    add(32'hDEADBEEF, 2'd1, 3'b010, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    add(32'hDEADBEEF, 2'd1, 3'b000, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
    add(32'hDEADBEEF, 2'd1, 3'b001, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
    // Reserved encodings
    add(32'h12345678, 2'd1, 3'b011, 1'b1, 32'h12345678, 1'b0, 1'b1);
    add(32'h12345678, 2'd2, 3'b110, 1'b1, 32'h12345678, 1'b0, 1'b1);
    add(32'h12345678, 2'd3, 3'b111, 1'b1, 32'h12345678, 1'b0, 1'b1);
    add(32'h12345678, 2'd1, 3'b011, 1'b0, 32'h12345678, 1'b0, 1'b0);
    add(32'h12345678, 2'd2, 3'b110, 1'b0, 32'h12345678, 1'b0, 1'b0);
    add(32'h12345678, 2'd3, 3'b111, 1'b0, 32'h12345678, 1'b0, 1'b0);

    // Reset held two cycles with an all-ones word load pending
    reset = 1'b1;
    RawMem = 32'hFFFFFFFF; ByteOff = 2'd0; funct3 = 3'b010; MemRdSignExtend = 1'b1;
    @(posedge clk); #1;
    check("reset_cycle1", 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("reset_cycle2", 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("after_reset", 32'hFFFFFFFF, 1'b0, 1'b0);

    // Back-to-back: new vector every cycle, each result one edge later
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_mis, vecs[i].exp_ill);
    end

    // Mid-stream reset discards the in-flight result, then stream resumes
    drive(vecs[2]);
    @(posedge clk); #1;
    check("pre_reset_lb", 32'hFFFFFFFF, 1'b0, 1'b0);
    drive(vecs[13]);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midstream_reset", 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    drive(vecs[7]);
    @(posedge clk); #1;
    check("post_reset_lh", 32'hFFFF8001, 1'b0, 1'b0);
    drive(vecs[17]);
    @(posedge clk); #1;
    check("post_reset_ill", 32'h12345678, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_sign_extender.md
Name: mem_sign_extender

Overview:
- Load-data formatter in the RV32I single-cycle datapath, placed between the data memory read port (rdata) and the write-back mux.
- Takes the raw 32-bit word read from data memory and selects the byte, halfword or word lane addressed by the load.
- Zero- or sign-extends the selected lane according to funct3 and delivers a registered 32-bit result with alignment and illegal-encoding flags.

Parameters:
- XLEN, 32, data width; only 32 is supported.
- REG_OUT, 1, 1 = registered outputs (one-cycle latency); 0 = combinational bypass, in which case reset has no effect on the outputs.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-high.
- RawMem  input  32  word from data memory; little-endian, byte 0 = bits 7:0.
- ByteOff  input  2  load address bits 1:0 (ALU result [1:0]).
- funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- MemRdSignExtend  input  1  1 = apply load formatting; 0 = pass RawMem through unchanged.
- ExtendedMem  output  32  formatted load data to the write-back mux.
- Misaligned  output  1  halfword/word access not naturally aligned.
- IllegalF3  output  1  funct3 is 011, 110 or 111 while MemRdSignExtend = 1.

Behaviour:
- Lane select (little-endian):
  - byte = RawMem[8*ByteOff +: 8].
  - halfword = RawMem[15:0] when ByteOff[1] = 0, RawMem[31:16] when ByteOff[1] = 1.
  - ByteOff[0] is ignored for halfword selection.
- Extension:
  - LB: {24{byte[7]}, byte}. LBU: {24'b0, byte}.
  - LH: {16{half[15]}, half}. LHU: {16'b0, half}.
  - LW: RawMem unchanged; ByteOff is ignored for data.
- Reserved funct3 (011, 110, 111) with MemRdSignExtend = 1: ExtendedMem = RawMem, IllegalF3 = 1.
- MemRdSignExtend = 0: ExtendedMem = RawMem; Misaligned = 0; IllegalF3 = 0.
- Misaligned:
  - 1 for LH/LHU with ByteOff[0] = 1.
  - 1 for LW with ByteOff != 00.
  - Data is still produced per the lane rules above; no trap is raised here.
- Timing with REG_OUT = 1:
  - All outputs update on rising clk from the inputs sampled at that edge; latency is 1 cycle.
  - No handshake; a new input is accepted every cycle.
- Reset with REG_OUT = 1:
  - When reset = 1 at a rising edge: ExtendedMem = 0, Misaligned = 0, IllegalF3 = 0.
  - Reset takes priority over inputs sampled at the same edge.
  - Reset asserted mid-stream discards the in-flight result.
  - The first valid output appears one cycle after reset deasserts.
- Combinational path: pure function of inputs; no latches; every funct3 value decoded explicitly.
- Unknown/X inputs are not required to be handled.

Decomposition:
- Shared package (riscv_pkg):
  - funct3 load constants F3_LB = 3'b000, F3_LH = 3'b001, F3_LW = 3'b010, F3_LBU = 3'b100, F3_LHU = 3'b101.
  - XLEN = 32.
- Same package is reused by aluctl and control.
- Natural sub-module: load_lane_select (combinational).
  - Inputs: RawMem, ByteOff.
  - Outputs: byte and halfword.
  - Consumed by the extension/flag logic and output register in mem_sign_extender.

Test Plan:
- Reset: reset = 1 for 2 cycles with RawMem = 0xFFFFFFFF, funct3 = 010 -> ExtendedMem = 0x00000000, flags 0. After release, next edge -> 0xFFFFFFFF.
- Bytes: RawMem = 0x80FF7F01, MemRdSignExtend = 1, LB with ByteOff 0/1/2/3 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. LBU with ByteOff = 3 -> 0x00000080.
- Halfwords: RawMem = 0x8001_7FFE.
  - LH ByteOff = 0 -> 0x00007FFE; LH ByteOff = 2 -> 0xFFFF8001.
  - LHU ByteOff = 2 -> 0x00008001.
  - LH ByteOff = 1 -> Misaligned = 1, data 0x00007FFE.
- Word and bypass:
  - LW RawMem = 0xDEADBEEF, ByteOff = 0 -> 0xDEADBEEF, flags 0.
  - LW ByteOff = 2 -> Misaligned = 1.
  - MemRdSignExtend = 0, funct3 = 000 -> 0xDEADBEEF.
- Reserved encodings: funct3 = 011/110/111 with MemRdSignExtend = 1 -> ExtendedMem = RawMem, IllegalF3 = 1. Same funct3 with MemRdSignExtend = 0 -> IllegalF3 = 0.
- Latency/back-to-back: change inputs every cycle across LB/LH/LW -> each result appears exactly one edge later with no dropped or duplicated values. Reset asserted mid-sequence -> zero output at that edge.
